xbee_frame_link: RTL
====================

Name: xbee_frame_link

Overview:
Parametrised successor to the fixed-format XBee transmit/echo-check path. It buffers up to PAYLOAD_MAX payload bytes and serialises them as an XBee API frame: 0x7E, 16-bit length, payload, checksum. The frame goes out over 8N1 UART at a parametrised baud. It receives the radio's echo on Rx, compares it byte-for-byte on the fly, and retries automatically up to MAX_RETRY times. Final status goes to the LCD status lines.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, UART bit rate; DIV = CLK_HZ/BAUD clock cycles per bit (integer division)
PAYLOAD_MAX, 16, payload buffer depth in bytes (1..255)
MAX_RETRY, 3, re-transmissions after the first attempt before declaring failure
ECHO_TIMEOUT, 40, bit-times allowed after the last TX stop bit for echo completion

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
ND  in  1  new-data strobe; writes Din into the payload buffer
Din  in  8  payload byte
Send  in  1  single-cycle pulse; starts a frame transmission
Abort  in  1  cancels any operation in progress
Rx  in  1  UART input carrying the echoed frame; idle high
DoutTx  out  1  UART output; idle high
BusyFlag  out  1  high from accepted Send until Done or Abort
Full  out  1  high when byte count = PAYLOAD_MAX
conf_LCD  out  2  00 idle, 11 busy, 01 echo OK, 10 failed
RetryCnt  out  clog2(MAX_RETRY+1)  retries used in the current/last attempt
Done  out  1  one-cycle pulse at final OK/FAIL

Behaviour:
- Reset values: DoutTx=1, BusyFlag=0, Full=0, conf_LCD=00, RetryCnt=0, Done=0. Byte count=0, FSM=IDLE.
- Reset mid-frame: the same values apply on the next edge, with no trailing bits.
- Load rules:
  - ND is accepted only in IDLE/OK/FAIL and only when count<PAYLOAD_MAX: buf[count]<=Din, count++.
  - ND is ignored when Full or while busy.
  - Full = (count==PAYLOAD_MAX), registered.
- Send rules:
  - Send is accepted in IDLE/OK/FAIL when count>0. Send with count=0 is ignored.
  - Send sampled at edge k: BusyFlag=1, conf_LCD=11, RetryCnt=0, and DoutTx=0 (start bit) from edge k+1.
- Frame byte sequence: 0x7E, 0x00, count, buf[0..count-1], CHK.
  - CHK = 0xFF - (sum of payload bytes mod 256).
  - Frame length = count+4 bytes.
- UART timing:
  - 8N1, LSB first, each bit exactly DIV cycles.
  - Bytes are back-to-back: the next start bit follows the stop bit with no gap.
- FSM states: IDLE, TX, WAIT_ECHO, GAP, OK, FAIL.
  - TX -> WAIT_ECHO after the final stop bit.
  - WAIT_ECHO -> OK when all count+4 echo bytes are received and matched.
  - WAIT_ECHO -> GAP on mismatch, framing error or timeout when RetryCnt<MAX_RETRY: RetryCnt++.
  - GAP lasts 1 bit-time with DoutTx=1, then -> TX, restarting from byte 0.
  - WAIT_ECHO -> FAIL on the same errors when RetryCnt==MAX_RETRY.
  - A mismatch detected during TX is latched and acted on at the TX->WAIT_ECHO transition. The current frame always completes.
- RX path:
  - Runs in TX and WAIT_ECHO, using a 2-flop synchroniser on Rx.
  - Start is detected on a falling edge and confirmed low at DIV/2; otherwise it is a false start and is ignored.
  - Data bits are sampled at DIV/2 of each bit. A stop bit sampled 0 is a framing error.
  - The echo index increments per received byte. Each byte is compared against the expected frame byte at that index.
  - Bytes received in IDLE/OK/FAIL/GAP are discarded.
- Timeout: WAIT_ECHO counts bit-times from entry. Echo incomplete after ECHO_TIMEOUT bit-times = attempt failure.
- OK:
  - conf_LCD=01 and Done=1 for one cycle, both on the edge of entering OK. BusyFlag=0 on the same edge.
  - count clears to 0, so the buffer is ready for new data.
- FAIL: conf_LCD=10, Done pulse, BusyFlag=0. Buffer and count are retained, so a new Send re-sends the same payload.
- Abort:
  - Abort has priority over Send/ND in the same cycle.
  - Any state -> IDLE on the next edge: DoutTx=1, BusyFlag=0, conf_LCD=00, no Done. Buffer and count are retained.
  - Abort mid-byte truncates the character.
- Send while busy is ignored.

Test Plan:
1. Bench CLK_HZ=1600, BAUD=100 (DIV=16), Rx tied to DoutTx. Load 0x11,0x22; Send -> DoutTx carries 7E 00 02 11 22 CC. Done pulse, conf_LCD=01, RetryCnt=0, count=0 afterwards.
2. Timing check, same bench -> start bit low exactly 16 cycles, beginning the edge after Send. Byte 0x7E bits are 0,1,1,1,1,1,1,0, then stop high. 6 bytes x 160 cycles with no inter-byte gap.
3. Rx held high, MAX_RETRY=3 -> 4 complete frames, each separated by a 16-cycle gap after timeout. conf_LCD=10, RetryCnt=3, Done once, Full/count unchanged.
4. Loopback with bit 0 of echo byte 3 flipped on attempt 1 only -> one retry. conf_LCD=01, RetryCnt=1. Stop bit forced 0 on attempt 1 -> same result.
5. 17 ND strobes with PAYLOAD_MAX=16 -> Full=1 after the 16th, 17th ignored. Length byte 0x10, checksum correct. ND during BusyFlag is ignored.
6. Abort in the middle of payload byte 2 -> DoutTx=1 and BusyFlag=0 on the next edge, conf_LCD=00, no Done. Reset mid-frame -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/xbee_frame_link_if.sv
// Host/radio-side signal bundle for xbee_frame_link.
// master: bench/host drives ND/Din/Send/Abort/Rx; slave: the link.
interface xbee_frame_link_if #(
   parameter int RW = 2
);
   logic          ND;
   logic [7:0]    Din;
   logic          Send;
   logic          Abort;
   logic          Rx;
   logic          DoutTx;
   logic          BusyFlag;
   logic          Full;
   logic [1:0]    conf_LCD;
   logic [RW-1:0] RetryCnt;
   logic          Done;

   modport master (
      output ND, Din, Send, Abort, Rx,
      input  DoutTx, BusyFlag, Full, conf_LCD, RetryCnt, Done
   );

   modport slave (
      input  ND, Din, Send, Abort, Rx,
      output DoutTx, BusyFlag, Full, conf_LCD, RetryCnt, Done
   );
endinterface

// File: rtl/xbee_frame_link.sv
// XBee API frame sender with on-the-fly echo check and auto retry.
// Ports: Clk, Reset (sync, high); bus = ND/Din load, Send/Abort, Rx echo,
//        DoutTx UART, BusyFlag, Full, conf_LCD, RetryCnt, Done.
module xbee_frame_link #(
   parameter int CLK_HZ       = 100000000,
   parameter int BAUD         = 9600,
   parameter int PAYLOAD_MAX  = 16,
   parameter int MAX_RETRY    = 3,
   parameter int ECHO_TIMEOUT = 40
) (
   input  logic             Clk,
   input  logic             Reset,
   xbee_frame_link_if.slave bus
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
   localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW  = $clog2(ECHO_TIMEOUT + 1);

   localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] C_LOAD = CW'(DIV - DIV / 2);
   localparam logic [7:0]    P_MAX  = 8'(PAYLOAD_MAX);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
   localparam logic [TW-1:0] T_LAST = TW'(ECHO_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_TX   = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_OK   = 3'd4;
   localparam logic [2:0] S_FAIL = 3'd5;

   logic [2:0]    r_state;
   logic [7:0]    r_cnt;
   logic [7:0]    r_sum;
   logic          r_full;
   logic          r_busy;
   logic [1:0]    r_lcd;
   logic [RW-1:0] r_retry;
   logic          r_done;
   logic          r_dout;
   logic [CW-1:0] r_bitc;
   logic [3:0]    r_bit;
   logic [8:0]    r_byte;
   logic [TW-1:0] r_tbits;
   logic [7:0]    r_buf [PAYLOAD_MAX];

   logic          r_s1, r_s2, r_s3;
   logic          r_rxon;
   logic [CW-1:0] r_rxc;
   logic [3:0]    r_rxbit;
   logic [7:0]    r_rxsh;
   logic [8:0]    r_eidx;
   logic          r_err;

   logic [8:0]    w_len;
   logic [7:0]    w_chk;
   logic [7:0]    w_txbyte;
   logic          w_txbit;
   logic          w_idle_like;
   logic          w_send_ok;
   logic          w_nd_ok;
   logic          w_rx_run;

   // Running sum is kept at load time so CHK needs no adder tree.
   assign w_len       = {1'b0, r_cnt} + 9'd4;
   assign w_chk       = 8'hFF - r_sum;
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_OK) ||
                        (r_state == S_FAIL);
   assign w_send_ok   = bus.Send && !bus.Abort && w_idle_like &&
                        (r_cnt != 8'd0);
   assign w_nd_ok     = bus.ND && !bus.Abort && w_idle_like &&
                        !r_full && !w_send_ok;
   assign w_rx_run    = (r_state == S_TX) || (r_state == S_WAIT);

   function automatic logic [7:0] f_byte(input logic [8:0] idx);
      logic [8:0] j;
      j = idx - 9'd3;
      if (idx == 9'd0)               return 8'h7E;
      else if (idx == 9'd1)          return 8'h00;
      else if (idx == 9'd2)          return r_cnt;
      else if (idx == w_len - 9'd1)  return w_chk;
      else                           return r_buf[j[AW-1:0]];
   endfunction

   // Bit 0 = start, 1..8 = data LSB first, 9 = stop.
   always_comb begin
      w_txbyte = f_byte(r_byte);
      w_txbit  = 1'b1;
      if (r_bit == 4'd0)
         w_txbit = 1'b0;
      else if (r_bit <= 4'd8)
         w_txbit = w_txbyte[r_bit[2:0] - 3'd1];
   end

   always_ff @(posedge Clk) begin
      if (!Reset && w_nd_ok)
         r_buf[r_cnt[AW-1:0]] <= bus.Din;
   end

   // DoutTx is registered from the state, so the line lags the FSM
   // by one cycle; Abort/Reset force it high directly.
   always_ff @(posedge Clk) begin
      r_done <= 1'b0;
      if (Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_full  <= 1'b0;
         r_busy  <= 1'b0;
         r_lcd   <= 2'b00;
         r_retry <= '0;
         r_dout  <= 1'b1;
         r_bitc  <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_tbits <= '0;
      end else if (bus.Abort) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_lcd   <= 2'b00;
         r_dout  <= 1'b1;
      end else begin
         if (w_nd_ok) begin
            r_cnt  <= r_cnt + 8'd1;
            r_sum  <= r_sum + bus.Din;
            r_full <= (r_cnt + 8'd1 == P_MAX);
         end
         case (r_state)
            S_TX: begin
               r_dout <= w_txbit;
               if (r_bitc == C_LAST) begin
                  r_bitc <= '0;
                  if (r_bit == 4'd9) begin
                     r_bit <= '0;
                     if (r_byte == w_len - 9'd1) begin
                        r_state <= S_WAIT;
                        r_byte  <= '0;
                        r_tbits <= '0;
                     end else begin
                        r_byte <= r_byte + 9'd1;
                     end
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end else begin
                  r_bitc <= r_bitc + CW'(1);
               end
            end
            S_WAIT: begin
               r_dout <= 1'b1;
               if (r_err || (r_bitc == C_LAST && r_tbits == T_LAST &&
                             r_eidx != w_len)) begin
                  r_bitc <= '0;
                  if (r_retry == R_MAX) begin
                     r_state <= S_FAIL;
                     r_lcd   <= 2'b10;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_GAP;
                     r_retry <= r_retry + RW'(1);
                  end
               end else if (r_eidx == w_len) begin
                  r_state <= S_OK;
                  r_lcd   <= 2'b01;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_full  <= 1'b0;
               end else if (r_bitc == C_LAST) begin
                  r_bitc  <= '0;
                  r_tbits <= r_tbits + TW'(1);
               end else begin
                  r_bitc <= r_bitc + CW'(1);
               end
            end
            S_GAP: begin
               r_dout <= 1'b1;
               if (r_bitc == C_LAST) begin
                  r_state <= S_TX;
                  r_bitc  <= '0;
                  r_bit   <= '0;
                  r_byte  <= '0;
               end else begin
                  r_bitc <= r_bitc + CW'(1);
               end
            end
            default: begin
               r_dout <= 1'b1;
               if (w_send_ok) begin
                  r_state <= S_TX;
                  r_busy  <= 1'b1;
                  r_lcd   <= 2'b11;
                  r_retry <= '0;
                  r_bitc  <= '0;
                  r_bit   <= '0;
                  r_byte  <= '0;
               end
            end
         endcase
      end
   end

   // Echo receiver: the counter is preloaded so its rollover lands
   // DIV/2 after the detected falling edge, then every DIV cycles.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_s3    <= 1'b1;
         r_rxon  <= 1'b0;
         r_rxc   <= '0;
         r_rxbit <= '0;
         r_rxsh  <= '0;
         r_eidx  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_s1 <= bus.Rx;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (!w_rx_run) begin
            r_rxon <= 1'b0;
            r_eidx <= '0;
            r_err  <= 1'b0;
         end else if (!r_rxon) begin
            if (r_s3 && !r_s2) begin
               r_rxon  <= 1'b1;
               r_rxc   <= C_LOAD;
               r_rxbit <= '0;
            end
         end else if (r_rxc == C_LAST) begin
            r_rxc <= '0;
            if (r_rxbit == 4'd0) begin
               if (r_s2)
                  r_rxon <= 1'b0;
               else
                  r_rxbit <= 4'd1;
            end else if (r_rxbit != 4'd9) begin
               r_rxsh  <= {r_s2, r_rxsh[7:1]};
               r_rxbit <= r_rxbit + 4'd1;
            end else begin
               r_rxon <= 1'b0;
               if (r_eidx != w_len) begin
                  r_eidx <= r_eidx + 9'd1;
                  if (!r_s2 || r_rxsh != f_byte(r_eidx))
                     r_err <= 1'b1;
               end
            end
         end else begin
            r_rxc <= r_rxc + CW'(1);
         end
      end
   end

   assign bus.DoutTx   = r_dout;
   assign bus.BusyFlag = r_busy;
   assign bus.Full     = r_full;
   assign bus.conf_LCD = r_lcd;
   assign bus.RetryCnt = r_retry;
   assign bus.Done     = r_done;
endmodule
